// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S datapath: instruction decode, ALU operation encodings and flags.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV,
        I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    } decoded_instruction_type;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic unsigned_ov;
        logic signed_ov;
    } flags_t;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNZERO = 8'h03;
    localparam logic [7:0] OP_BNEG   = 8'h04;
    localparam logic [7:0] OP_BNNEG  = 8'h05;
    localparam logic [7:0] OP_BOV    = 8'h06;
    localparam logic [7:0] OP_BNOV   = 8'h07;
    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h83;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    // Unlisted opcodes decode as NOP so a corrupted IR never triggers a side effect.
    function automatic decoded_instruction_type decode_opcode(input logic [7:0] opcode);
        case (opcode)
            OP_BRANCH: return I_BRANCH;
            OP_BZERO:  return I_BZERO;
            OP_BNZERO: return I_BNZERO;
            OP_BNEG:   return I_BNEG;
            OP_BNNEG:  return I_BNNEG;
            OP_BOV:    return I_BOV;
            OP_BNOV:   return I_BNOV;
            OP_LOAD:   return I_LOAD;
            OP_STORE:  return I_STORE;
            OP_MOVE:   return I_MOVE;
            OP_ADD:    return I_ADD;
            OP_SUB:    return I_SUB;
            OP_AND:    return I_AND;
            OP_OR:     return I_OR;
            OP_HALT:   return I_HALT;
            default:   return I_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ks_alu.sv
// Combinational 16-bit ALU: add/sub/and/or with zero, negative, carry/borrow and signed-overflow flags.
module ks_alu
    import k_and_s_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  alu_op_t     op,
    output logic [15:0] result,
    output flags_t      flags
);

    logic [16:0] sum;
    logic [16:0] diff;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        flags  = '0;
        case (op)
            ALU_ADD: begin
                result            = sum[15:0];
                flags.unsigned_ov = sum[16];
                flags.signed_ov   = (a[15] == b[15]) && (result[15] != a[15]);
            end
            ALU_SUB: begin
                // The 17th bit of the widened difference is the borrow, i.e. a < b unsigned.
                result            = diff[15:0];
                flags.unsigned_ov = diff[16];
                flags.signed_ov   = (a[15] != b[15]) && (result[15] != a[15]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
        endcase
        flags.zero = (result == 16'h0000);
        flags.neg  = result[15];
    end

endmodule

// File: rtl/datapath.sv
// K-and-S datapath: PC, IR, four-entry register file and flags register around the ks_alu.
module datapath
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    flags_reg_enable,
    input  logic [1:0]              operation,
    input  logic [15:0]             data_in,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    output logic [15:0]             data_out
);

    logic [4:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] regs_q [4];
    logic [15:0] regs_d [4];
    flags_t      flags_q, flags_d;

    logic [1:0]  dest_sel, a_sel, b_sel;
    logic [15:0] alu_result, write_data;
    flags_t      alu_flags;
    logic        unused_ir_bit;

    assign unused_ir_bit       = ir_q[7];
    assign decoded_instruction = decode_opcode(ir_q[15:8]);

    always_comb begin
        dest_sel = ir_q[5:4];
        a_sel    = ir_q[3:2];
        b_sel    = ir_q[1:0];
        case (decoded_instruction)
            I_LOAD: dest_sel = ir_q[6:5];
            I_MOVE: begin
                // MOVE feeds the source to both operands; the controller picks an op that passes it through.
                dest_sel = ir_q[3:2];
                a_sel    = ir_q[1:0];
            end
            default: ;
        endcase
    end

    ks_alu u_alu (
        .a      (regs_q[a_sel]),
        .b      (regs_q[b_sel]),
        .op     (alu_op_t'(operation)),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign write_data = c_sel ? data_in : alu_result;
    assign ram_addr   = addr_sel ? ir_q[4:0] : pc_q;
    assign data_out   = regs_q[ir_q[6:5]];

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        flags_d = flags_q;
        if (pc_enable) pc_d = branch ? ir_q[4:0] : pc_q + 5'd1;
        if (ir_enable) ir_d = data_in;
        if (write_reg_enable) regs_d[dest_sel] = write_data;
        if (flags_reg_enable) flags_d = alu_flags;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            // NOTE: the register file is small and architecturally visible, so each entry is reset.
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            regs_q  <= regs_d;
        end
    end

    assign zero_op           = flags_q.zero;
    assign neg_op            = flags_q.neg;
    assign unsigned_overflow = flags_q.unsigned_ov;
    assign signed_overflow   = flags_q.signed_ov;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath: reset, fetch, ALU flags, memory access, move, decode, branch.
module tb_datapath;
    import k_and_s_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    branch = 1'b0, pc_enable = 1'b0, ir_enable = 1'b0;
    logic                    write_reg_enable = 1'b0, addr_sel = 1'b0, c_sel = 1'b0;
    logic                    flags_reg_enable = 1'b0;
    logic [1:0]              operation = 2'b00;
    logic [15:0]             data_in = 16'h0000;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]              ram_addr;
    logic [15:0]             data_out;

    int checks = 0;
    int errors = 0;

    localparam int N_DEC = 19;
    localparam logic [7:0] DEC_OPS [N_DEC] = '{
        8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h81, 8'h82,
        8'h83, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF, 8'h42, 8'h84, 8'hA0};
    localparam decoded_instruction_type DEC_EXP [N_DEC] = '{
        I_NOP, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_LOAD, I_STORE,
        I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT, I_NOP, I_NOP, I_NOP};

    datapath dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .flags_reg_enable    (flags_reg_enable),
        .operation           (operation),
        .data_in             (data_in),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] flags_now();
        return {zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; write_reg_enable = 1'b0;
        addr_sel = 1'b0; c_sel = 1'b0; flags_reg_enable = 1'b0; operation = 2'b00;
    endtask

    task automatic fetch(input logic [15:0] instr);
        data_in = instr;
        ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [15:0] val);
        fetch({8'h81, 1'b0, r, 5'd0});
        c_sel = 1'b1; write_reg_enable = 1'b1; data_in = val;
        tick();
        clear_ctrl();
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [15:0] val);
        fetch({8'h82, 1'b0, r, 5'd0});
        val = data_out;
    endtask

    task automatic alu_exec(input logic [15:0] instr, input logic [1:0] op, input logic flags_en);
        fetch(instr);
        operation = op; write_reg_enable = 1'b1; flags_reg_enable = flags_en;
        tick();
        clear_ctrl();
    endtask

    task automatic test_reset();
        // Enables active while rst is held must not disturb the reset state.
        pc_enable = 1'b1; ir_enable = 1'b1; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
        c_sel = 1'b1; data_in = 16'hFFFF;
        tick(); tick();
        clear_ctrl();
        checks++; if (ram_addr !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", ram_addr); end
        checks++; if (decoded_instruction !== I_NOP) begin errors++; $display("FAIL reset_decode: got %0d expected %0d", decoded_instruction, I_NOP); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
        checks++; if (flags_now() !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags_now()); end
        addr_sel = 1'b1; #1;
        checks++; if (ram_addr !== 5'd0) begin errors++; $display("FAIL reset_ir_addr: got %0d expected 0", ram_addr); end
        addr_sel = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        pc_enable = 1'b1;
        tick(); tick(); tick();
        pc_enable = 1'b0;
        checks++; if (ram_addr !== 5'd3) begin errors++; $display("FAIL pc_count: got %0d expected 3", ram_addr); end
        data_in = 16'hA11B; ir_enable = 1'b1; pc_enable = 1'b1;
        tick();
        clear_ctrl();
        checks++; if (ram_addr !== 5'd4) begin errors++; $display("FAIL fetch_pc: got %0d expected 4", ram_addr); end
        checks++; if (decoded_instruction !== I_ADD) begin errors++; $display("FAIL fetch_decode: got %0d expected %0d", decoded_instruction, I_ADD); end
        addr_sel = 1'b1; #1;
        checks++; if (ram_addr !== 5'h1B) begin errors++; $display("FAIL fetch_ir_addr: got %0d expected 27", ram_addr); end
        addr_sel = 1'b0;
    endtask

    task automatic test_add();
        logic [15:0] v;
        load_reg(2'd2, 16'h7FFF);
        load_reg(2'd3, 16'h0001);
        alu_exec(16'hA11B, 2'b00, 1'b1);
        checks++; if (flags_now() !== 4'b0101) begin errors++; $display("FAIL add_sov_flags: got %b expected 0101", flags_now()); end
        read_reg(2'd1, v);
        checks++; if (v !== 16'h8000) begin errors++; $display("FAIL add_sov_result: got %h expected 8000", v); end
        load_reg(2'd2, 16'hFFFF);
        alu_exec(16'hA11B, 2'b00, 1'b1);
        checks++; if (flags_now() !== 4'b1010) begin errors++; $display("FAIL add_carry_flags: got %b expected 1010", flags_now()); end
        read_reg(2'd1, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL add_carry_result: got %h expected 0000", v); end
        load_reg(2'd2, 16'h0001);
        alu_exec(16'hA11B, 2'b00, 1'b0);
        checks++; if (flags_now() !== 4'b1010) begin errors++; $display("FAIL flags_hold: got %b expected 1010", flags_now()); end
        read_reg(2'd1, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL add_noflags_result: got %h expected 0002", v); end
    endtask

    task automatic test_sub_logic();
        logic [15:0] v;
        load_reg(2'd0, 16'h0000);
        load_reg(2'd1, 16'h0001);
        alu_exec(16'hA221, 2'b01, 1'b1);
        checks++; if (flags_now() !== 4'b0110) begin errors++; $display("FAIL sub_borrow_flags: got %b expected 0110", flags_now()); end
        read_reg(2'd2, v);
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL sub_borrow_result: got %h expected FFFF", v); end
        load_reg(2'd0, 16'h8000);
        alu_exec(16'hA221, 2'b01, 1'b1);
        checks++; if (flags_now() !== 4'b0001) begin errors++; $display("FAIL sub_sov_flags: got %b expected 0001", flags_now()); end
        read_reg(2'd2, v);
        checks++; if (v !== 16'h7FFF) begin errors++; $display("FAIL sub_sov_result: got %h expected 7FFF", v); end
        alu_exec(16'hA421, 2'b11, 1'b1);
        checks++; if (flags_now() !== 4'b0100) begin errors++; $display("FAIL or_flags: got %b expected 0100", flags_now()); end
        read_reg(2'd2, v);
        checks++; if (v !== 16'h8001) begin errors++; $display("FAIL or_result: got %h expected 8001", v); end
        alu_exec(16'hA321, 2'b10, 1'b1);
        checks++; if (flags_now() !== 4'b1000) begin errors++; $display("FAIL and_flags: got %b expected 1000", flags_now()); end
        read_reg(2'd2, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL and_result: got %h expected 0000", v); end
    endtask

    task automatic test_move();
        logic [15:0] v;
        load_reg(2'd1, 16'h5A5A);
        alu_exec(16'h830D, 2'b11, 1'b0);
        read_reg(2'd3, v);
        checks++; if (v !== 16'h5A5A) begin errors++; $display("FAIL move_result: got %h expected 5A5A", v); end
        read_reg(2'd1, v);
        checks++; if (v !== 16'h5A5A) begin errors++; $display("FAIL move_src_kept: got %h expected 5A5A", v); end
    endtask

    task automatic test_memory();
        load_reg(2'd2, 16'hABCD);
        fetch(16'h8145);
        checks++; if (decoded_instruction !== I_LOAD) begin errors++; $display("FAIL load_decode: got %0d expected %0d", decoded_instruction, I_LOAD); end
        addr_sel = 1'b1; c_sel = 1'b1; write_reg_enable = 1'b1; data_in = 16'h1234;
        #1;
        checks++; if (ram_addr !== 5'd5) begin errors++; $display("FAIL load_addr: got %0d expected 5", ram_addr); end
        checks++; if (data_out !== 16'hABCD) begin errors++; $display("FAIL same_cycle_old: got %h expected ABCD", data_out); end
        tick();
        clear_ctrl();
        checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL load_new_value: got %h expected 1234", data_out); end
        fetch(16'h824A);
        addr_sel = 1'b1; #1;
        checks++; if (ram_addr !== 5'd10) begin errors++; $display("FAIL store_addr: got %0d expected 10", ram_addr); end
        checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL store_data: got %h expected 1234", data_out); end
        checks++; if (decoded_instruction !== I_STORE) begin errors++; $display("FAIL store_decode: got %0d expected %0d", decoded_instruction, I_STORE); end
        addr_sel = 1'b0;
    endtask

    task automatic test_decode();
        for (int i = 0; i < N_DEC; i++) begin
            fetch({DEC_OPS[i], 8'h00});
            checks++;
            if (decoded_instruction !== DEC_EXP[i]) begin
                errors++;
                $display("FAIL decode_%h: got %0d expected %0d", DEC_OPS[i], decoded_instruction, DEC_EXP[i]);
            end
        end
    endtask

    task automatic test_branch();
        // PC is 4 here: only the fetch test advanced it.
        pc_enable = 1'b1;
        for (int i = 0; i < 27; i++) tick();
        pc_enable = 1'b0;
        checks++; if (ram_addr !== 5'd31) begin errors++; $display("FAIL pc_at_31: got %0d expected 31", ram_addr); end
        pc_enable = 1'b1;
        tick();
        pc_enable = 1'b0;
        checks++; if (ram_addr !== 5'd0) begin errors++; $display("FAIL pc_wrap: got %0d expected 0", ram_addr); end
        fetch(16'h0111);
        checks++; if (decoded_instruction !== I_BRANCH) begin errors++; $display("FAIL branch_decode: got %0d expected %0d", decoded_instruction, I_BRANCH); end
        branch = 1'b1; pc_enable = 1'b1;
        tick();
        pc_enable = 1'b0;
        checks++; if (ram_addr !== 5'd17) begin errors++; $display("FAIL branch_target: got %0d expected 17", ram_addr); end
        tick();
        branch = 1'b0;
        checks++; if (ram_addr !== 5'd17) begin errors++; $display("FAIL branch_hold: got %0d expected 17", ram_addr); end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] v;
        load_reg(2'd0, 16'h1111);
        load_reg(2'd1, 16'h2222);
        alu_exec(16'hA231, 2'b01, 1'b1);
        fetch(16'h8245);
        pc_enable = 1'b1; addr_sel = 1'b1; data_in = 16'hA11B;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (decoded_instruction !== I_NOP) begin errors++; $display("FAIL midrun_decode: got %0d expected %0d", decoded_instruction, I_NOP); end
        checks++; if (ram_addr !== 5'd0) begin errors++; $display("FAIL midrun_ir_addr: got %0d expected 0", ram_addr); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL midrun_data_out: got %h expected 0000", data_out); end
        checks++; if (flags_now() !== 4'b0000) begin errors++; $display("FAIL midrun_flags: got %b expected 0000", flags_now()); end
        clear_ctrl();
        #1;
        checks++; if (ram_addr !== 5'd0) begin errors++; $display("FAIL midrun_pc: got %0d expected 0", ram_addr); end
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], v);
            checks++;
            if (v !== 16'h0000) begin errors++; $display("FAIL midrun_reg%0d: got %h expected 0000", r, v); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_add();
        test_sub_logic();
        test_move();
        test_memory();
        test_decode();
        test_branch();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have control inputs, each 1 bit: branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable.
REQ-004 SHALL have: operation  input  2  ALU select (00 add, 01 sub, 10 and, 11 or).
REQ-005 SHALL have: decoded_instruction  output  decoded_instruction_type  decode of IR.
REQ-006 SHALL have flag outputs, each 1 bit, registered: zero_op, neg_op, unsigned_overflow, signed_overflow.
REQ-007 SHALL have: ram_addr  output  5  memory address.
REQ-008 SHALL have: data_out  output  16  store data; data_in  input  16  memory read data.

Function
REQ-009 SHALL hold PC (5 bit), IR (16 bit), four 16-bit registers R0-R3 and a 4-bit flags register.
REQ-010 SHALL, when pc_enable=1, load PC with IR[4:0] if branch=1, else PC+1, wrapping 31->0.
REQ-011 SHALL, when ir_enable=1, load IR from data_in.
REQ-012 SHALL drive ram_addr combinationally: IR[4:0] when addr_sel=1, else PC.
REQ-013 SHALL decode IR[15:8]: 00 NOP, 01 BRANCH, 02 BZERO, 03 BNZERO, 04 BNEG, 05 BNNEG, 06 BOV, 07 BNOV, 81 LOAD, 82 STORE, 83 MOVE, A1 ADD, A2 SUB, A3 AND, A4 OR, FF HALT; any other value -> NOP.
REQ-014 SHALL use register fields: ALU ops C=IR[5:4], A=IR[3:2], B=IR[1:0]; LOAD/STORE reg=IR[6:5]; MOVE dest=IR[3:2], src=IR[1:0], with src driven on both ALU operands.
REQ-015 SHALL, when write_reg_enable=1, write the destination register for the current instruction with data_in if c_sel=1, else the ALU result.
REQ-016 SHALL drive data_out combinationally from the register at IR[6:5].
REQ-017 SHALL compute ALU result as 16 bits modulo 2^16.
REQ-018 SHALL compute zero = result==0 and neg = result[15].
REQ-019 SHALL compute unsigned overflow as carry-out on add and as borrow (A<B) on sub.
REQ-020 SHALL compute signed overflow by two's-complement rules on add/sub.
REQ-021 SHALL clear both overflow flags for and/or.
REQ-022 SHALL load the flags register with the four ALU flags when flags_reg_enable=1 and hold them otherwise.
REQ-023 SHALL, when ir_enable and pc_enable are both 1, capture data_in (from the old PC) into IR and advance PC in the same edge.
REQ-024 SHALL return the old register value on a same-cycle read of the register being written; the new value is visible next cycle.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-instruction, immediately clear PC, IR, R0-R3 and all flags to 0, so decoded_instruction=I_NOP, ram_addr=0 and data_out=0.
REQ-026 SHALL hold all state at reset values until the first rising clk after rst deasserts.

Structure
REQ-027 SHALL keep the following in k_and_s_pkg: decoded_instruction_type, the opcode constants and the ALU operation encodings.
REQ-028 SHALL instantiate the ALU as a combinational sub-module named ks_alu; all state stays in datapath.

Verification
REQ-029 Reset: rst pulse mid-run -> PC=0, IR=0, R0-R3=0, flags=0, decoded_instruction=I_NOP.
REQ-030 Fetch: data_in=16'hA1_1B with ir_enable=pc_enable=1, PC=3 -> IR=A11B, PC=4, decoded_instruction=I_ADD.
REQ-031 Add overflow: R2=16'h7FFF, R3=16'h0001, IR=A1_1B, op=00, write_reg_enable and flags_reg_enable -> R1=16'h8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
REQ-032 Sub: R0=0, R1=1, IR=A2_21, op=01 -> R2=16'hFFFF, unsigned_overflow=1, neg=1; and with R0 -> zero=1, both overflows 0.
REQ-033 Memory: IR=81_45, addr_sel=1, c_sel=1, write_reg_enable, data_in=16'h1234 -> ram_addr=5, R2=1234; IR=82_4A -> ram_addr=10, data_out=1234.
REQ-034 Branch and wrap: PC=31, pc_enable=1 -> PC=0; IR=01_11, branch=1, pc_enable=1 -> PC=17.
